// File: rtl/gray_slot_sched.sv
// Round-robin time-slot scheduler driving a shared Gray-coded slot counter.
// Optional macro GRAY_SLOT_GAP_EN inserts one idle guard cycle after every slot end.
module gray_slot_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SBITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             hold,
    output logic [NREQ-1:0]  grant,
    output logic [SBITS-1:0] gray_cnt,
    output logic             slot_end,
    output logic             busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t           r_state;
    logic [SBITS-1:0] r_cnt;
    logic [SBITS-1:0] r_gray;
    logic [NREQ-1:0]  r_grant;
    logic [PW-1:0]    r_ptr;
    logic             r_slot_end;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_idx;
    logic [NREQ-1:0]  w_onehot;
    logic [SBITS-1:0] w_cnt_inc;
    logic             w_release;
    logic             w_wrap;

    // Scan downward so the lowest offset from ptr+1 is written last and wins;
    // offset NREQ lands on the current holder, which therefore competes last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = PW'((int'(r_ptr) + i) % int'(NREQ));
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_onehot  = NREQ'(1) << w_win;
    assign w_cnt_inc = r_cnt + SBITS'(1);
    assign w_release = ((r_grant & req) == '0);
    assign w_wrap    = !hold && (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_gray     <= '0;
            r_grant    <= '0;
            r_ptr      <= PW'(NREQ - 1);
            r_slot_end <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_slot_end <= 1'b0;
                    r_cnt      <= '0;
                    r_gray     <= '0;
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_ptr   <= w_win;
                        r_state <= StRun;
                    end else begin
                        r_grant <= '0;
                    end
                end
                StRun: begin
                    if (w_release || w_wrap) begin
                        // Natural wrap and early release collapse into one slot end.
                        r_slot_end <= 1'b1;
                        r_cnt      <= '0;
                        r_gray     <= '0;
`ifdef GRAY_SLOT_GAP_EN
                        r_grant    <= '0;
                        r_state    <= StIdle;
`else
                        if (w_found) begin
                            r_grant <= w_onehot;
                            r_ptr   <= w_win;
                        end else begin
                            r_grant <= '0;
                            r_state <= StIdle;
                        end
`endif
                    end else if (hold) begin
                        r_slot_end <= 1'b0;
                    end else begin
                        r_slot_end <= 1'b0;
                        r_cnt      <= w_cnt_inc;
                        r_gray     <= w_cnt_inc ^ (w_cnt_inc >> 1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign gray_cnt = r_gray;
    assign slot_end = r_slot_end;
    assign busy     = (r_state == StRun);

endmodule

// File: tb/tb_gray_slot_sched.sv
// Directed self-checking bench for gray_slot_sched (NREQ=4, SBITS=3).
// Build with GRAY_SLOT_GAP_EN defined to exercise the guard-cycle variant instead.
module tb_gray_slot_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       hold;
    logic [3:0] grant;
    logic [2:0] gray_cnt;
    logic       slot_end;
    logic       busy;

    int n_pass;
    int n_total;

    logic [2:0] gray_seq [8];
    logic [3:0] rr_seq   [5];

    gray_slot_sched #(
        .NREQ  (4),
        .SBITS (3)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .hold     (hold),
        .grant    (grant),
        .gray_cnt (gray_cnt),
        .slot_end (slot_end),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        hold = 1'b0;
        step(1);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({grant, gray_cnt, slot_end, busy} !== 9'b0) begin
            $display("FAIL reset_outputs: got grant=%b gray=%b se=%b busy=%b, want all 0",
                     grant, gray_cnt, slot_end, busy);
        end else n_pass++;
        step(2);
        n_total++;
        if ({grant, busy} !== 5'b0) begin
            $display("FAIL idle_no_req: got grant=%b busy=%b, want 0000/0", grant, busy);
        end else n_pass++;
    endtask

`ifndef GRAY_SLOT_GAP_EN
    task automatic test_single_req();
        do_reset();
        req = 4'b0001;
        step(1);
        n_total++;
        if (grant !== 4'b0001 || busy !== 1'b1 || gray_cnt !== 3'b000 || slot_end !== 1'b0) begin
            $display("FAIL single_first_grant: got grant=%b busy=%b gray=%b se=%b, want 0001/1/000/0",
                     grant, busy, gray_cnt, slot_end);
        end else n_pass++;
        for (int k = 1; k < 8; k++) begin
            step(1);
            n_total++;
            if (gray_cnt !== gray_seq[k] || slot_end !== 1'b0 || grant !== 4'b0001) begin
                $display("FAIL single_gray_%0d: got gray=%b se=%b grant=%b, want %b/0/0001",
                         k, gray_cnt, slot_end, grant, gray_seq[k]);
            end else n_pass++;
        end
        step(1);
        n_total++;
        if (gray_cnt !== 3'b000 || slot_end !== 1'b1 || grant !== 4'b0001 || busy !== 1'b1) begin
            $display("FAIL single_wrap: got gray=%b se=%b grant=%b busy=%b, want 000/1/0001/1",
                     gray_cnt, slot_end, grant, busy);
        end else n_pass++;
        step(1);
        n_total++;
        if (gray_cnt !== 3'b001 || slot_end !== 1'b0) begin
            $display("FAIL single_after_wrap: got gray=%b se=%b, want 001/0", gray_cnt, slot_end);
        end else n_pass++;
    endtask

    task automatic test_round_robin();
        int se_cnt;
        do_reset();
        req = 4'b1111;
        step(1);
        n_total++;
        if (grant !== rr_seq[0]) begin
            $display("FAIL rr_grant_0: got %b, want %b", grant, rr_seq[0]);
        end else n_pass++;
        for (int s = 1; s < 5; s++) begin
            se_cnt = 0;
            for (int k = 0; k < 7; k++) begin
                step(1);
                if (slot_end === 1'b1) se_cnt++;
            end
            step(1);
            if (slot_end === 1'b1) se_cnt++;
            n_total++;
            if (grant !== rr_seq[s] || slot_end !== 1'b1 || gray_cnt !== 3'b000) begin
                $display("FAIL rr_grant_%0d: got grant=%b se=%b gray=%b, want %b/1/000",
                         s, grant, slot_end, gray_cnt, rr_seq[s]);
            end else n_pass++;
            n_total++;
            if (se_cnt != 1) begin
                $display("FAIL rr_pulses_%0d: got %0d slot_end pulses, want 1", s, se_cnt);
            end else n_pass++;
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0011;
        step(1);
        step(2);
        n_total++;
        if (grant !== 4'b0001 || gray_cnt !== 3'b011) begin
            $display("FAIL early_setup: got grant=%b gray=%b, want 0001/011", grant, gray_cnt);
        end else n_pass++;
        req = 4'b0010;
        step(1);
        n_total++;
        if (grant !== 4'b0010 || gray_cnt !== 3'b000 || slot_end !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL early_release: got grant=%b gray=%b se=%b busy=%b, want 0010/000/1/1",
                     grant, gray_cnt, slot_end, busy);
        end else n_pass++;
    endtask

    // Continues from the early-release slot held by requester 1.
    task automatic test_hold();
        step(3);
        n_total++;
        if (gray_cnt !== 3'b010 || grant !== 4'b0010) begin
            $display("FAIL hold_setup: got gray=%b grant=%b, want 010/0010", gray_cnt, grant);
        end else n_pass++;
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            n_total++;
            if (gray_cnt !== 3'b010 || slot_end !== 1'b0 || grant !== 4'b0010) begin
                $display("FAIL hold_frozen_%0d: got gray=%b se=%b grant=%b, want 010/0/0010",
                         k, gray_cnt, slot_end, grant);
            end else n_pass++;
        end
        hold = 1'b0;
        step(1);
        n_total++;
        if (gray_cnt !== 3'b110) begin
            $display("FAIL hold_resume: got gray=%b, want 110", gray_cnt);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        req = 4'b0100;
        step(1);
        step(5);
        n_total++;
        if (grant !== 4'b0100 || gray_cnt !== 3'b111) begin
            $display("FAIL midrst_setup: got grant=%b gray=%b, want 0100/111", grant, gray_cnt);
        end else n_pass++;
        rst = 1'b1;
        step(1);
        n_total++;
        if ({grant, gray_cnt, slot_end, busy} !== 9'b0) begin
            $display("FAIL midrst_clear: got grant=%b gray=%b se=%b busy=%b, want all 0",
                     grant, gray_cnt, slot_end, busy);
        end else n_pass++;
        rst = 1'b0;
        req = 4'b1111;
        step(1);
        n_total++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            $display("FAIL midrst_first_grant: got grant=%b busy=%b, want 0001/1", grant, busy);
        end else n_pass++;
    endtask
`else
    task automatic test_gap();
        do_reset();
        req = 4'b0011;
        step(1);
        n_total++;
        if (grant !== 4'b0001) begin
            $display("FAIL gap_first: got %b, want 0001", grant);
        end else n_pass++;
        for (int s = 0; s < 2; s++) begin
            step(8);
            n_total++;
            if (grant !== 4'b0000 || busy !== 1'b0 || slot_end !== 1'b1 || gray_cnt !== 3'b000) begin
                $display("FAIL gap_guard_%0d: got grant=%b busy=%b se=%b gray=%b, want 0000/0/1/000",
                         s, grant, busy, slot_end, gray_cnt);
            end else n_pass++;
            step(1);
            n_total++;
            if (grant !== ((s == 0) ? 4'b0010 : 4'b0001) || busy !== 1'b1 || slot_end !== 1'b0) begin
                $display("FAIL gap_next_%0d: got grant=%b busy=%b se=%b, want %b/1/0",
                         s, grant, busy, slot_end, (s == 0) ? 4'b0010 : 4'b0001);
            end else n_pass++;
        end
    endtask
`endif

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        hold     = 1'b0;
        gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        rr_seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        test_reset();
`ifndef GRAY_SLOT_GAP_EN
        test_single_req();
        test_round_robin();
        test_early_release();
        test_hold();
        test_reset_mid_slot();
`else
        test_gap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
